// File: rtl/io_bus_responder.sv
// io_bus_responder
// Memory-side responder for the CPU's single-port bus. An address at or above
// IO_MEM selects the I/O register file (LED, synchronized switches and an
// optional prescaled timer). Anything below IO_MEM goes to block RAM. I/O read
// data is registered so that the CPU sees the same one-cycle read latency as
// the RAM's registered output.
//
// Build option: define IO_TIMER_EN to implement the prescaler, TCNT, TCMP and
// STAT. When it is undefined, offsets 2..4 read 0 and ignore writes, irq is 0,
// and no timer flops exist.
//
// Register map (offset = adr - IO_MEM):
//   0 LED  RW  bits [7:0]
//   1 SW   RO  2-flop synchronized sw, zero-extended
//   2 TCNT RW  16-bit tick counter
//   3 TCMP RW  compare value
//   4 STAT     bit0 match flag (write 1 to clear), bit1 irq enable (RW)
//   5+         read 0, writes ignored
module io_bus_responder #(
    parameter int unsigned WIDTH    = 16,
    parameter logic [15:0] IO_MEM   = 16'hCFFD,
    parameter int unsigned PRESCALE = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      adr,
    input  logic [WIDTH-1:0] memOut,
    input  logic             memwrite_a,
    input  logic [WIDTH-1:0] ram_q,
    output logic             ram_we,
    output logic [WIDTH-1:0] memdata,
    input  logic [7:0]       sw,
    output logic [7:0]       led,
    output logic             irq
);

    typedef enum logic [2:0] {
        REG_LED  = 3'd0,
        REG_SW   = 3'd1,
        REG_TCNT = 3'd2,
        REG_TCMP = 3'd3,
        REG_STAT = 3'd4
    } reg_e;

    // A prescaler of zero cycles per tick is meaningless; stop elaboration.
    if (PRESCALE == 0) begin : g_bad_prescale
        $error("io_bus_responder: PRESCALE must be at least 1");
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic        io_hit;
    logic [15:0] off;
    logic        reg_valid;
    reg_e        reg_sel;
    logic        io_we;
    logic [7:0]  wdata8;

    assign io_hit    = (adr >= IO_MEM);
    assign off       = adr - IO_MEM;
    assign reg_valid = io_hit && (off < 16'd5);
    assign reg_sel   = reg_e'(off[2:0]);
    assign io_we     = memwrite_a && io_hit;
    assign wdata8    = 8'(memOut);

    // I/O writes never reach RAM.
    assign ram_we = memwrite_a && !io_hit;

    // Not every write-data bit lands in a register in every build.
    logic unused_wdata;
    assign unused_wdata = ^memOut;

    // ------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------
    logic [7:0] led_q, led_d;

    // LED next state: load the low byte on a write to offset 0.
    // NOTE: every always_comb starts by assigning a default to each output it
    // drives, so no path can leave a value unassigned and infer a latch.
    always_comb begin
        led_d = led_q;
        if (io_we && reg_valid && reg_sel == REG_LED) begin
            led_d = wdata8;
        end
    end

    // LED state register.
    // NOTE: reset is asynchronous active-low, so it sits in the sensitivity
    // list and takes effect without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every flop samples values from before the edge.
            led_q <= led_d;
        end
    end

    assign led = led_q;

    // ------------------------------------------------------------------
    // Switch synchronizer
    // ------------------------------------------------------------------
    logic [7:0] sw_meta_q;
    logic [7:0] sw_sync_q;

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Optional timer
    // ------------------------------------------------------------------
`ifdef IO_TIMER_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   tcnt_q, tcnt_d;
    logic [15:0]   tcmp_q, tcmp_d;
    logic          flag_q, flag_d;
    logic          en_q, en_d;
    logic          tick;
    logic          wr_tcnt, wr_tcmp, wr_stat;
    logic [15:0]   wdata16;

    assign wdata16 = 16'(memOut);
    assign wr_tcnt = io_we && reg_valid && reg_sel == REG_TCNT;
    assign wr_tcmp = io_we && reg_valid && reg_sel == REG_TCMP;
    assign wr_stat = io_we && reg_valid && reg_sel == REG_STAT;

    // Timer next state. A CPU write to TCNT overrides the tick increment, while
    // the compare always looks at the pre-increment, pre-write count. A match
    // setting the flag beats a simultaneous write-1-to-clear.
    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
        tcnt_d  = tcnt_q;
        tcmp_d  = tcmp_q;
        flag_d  = flag_q;
        en_d    = en_q;

        if (tick) begin
            tcnt_d = tcnt_q + 16'd1;
        end
        if (wr_tcnt) begin
            tcnt_d = wdata16;
        end
        if (wr_tcmp) begin
            tcmp_d = wdata16;
        end
        if (wr_stat) begin
            en_d = wdata16[1];
            if (wdata16[0]) begin
                flag_d = 1'b0;
            end
        end
        if (tick && tcnt_q == tcmp_q) begin
            flag_d = 1'b1;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            tcnt_q  <= '0;
            tcmp_q  <= 16'hFFFF;
            flag_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tcnt_q  <= tcnt_d;
            tcmp_q  <= tcmp_d;
            flag_q  <= flag_d;
            en_q    <= en_d;
        end
    end

    assign irq = flag_q && en_q;
`else
    assign irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic             io_sel_q;
    logic [WIDTH-1:0] io_rdata_q, io_rdata_d;

    // Decode the register value addressed this cycle (pre-write contents).
    always_comb begin
        io_rdata_d = '0;
        if (reg_valid) begin
            case (reg_sel)
                REG_LED:  io_rdata_d = WIDTH'(led_q);
                REG_SW:   io_rdata_d = WIDTH'(sw_sync_q);
`ifdef IO_TIMER_EN
                REG_TCNT: io_rdata_d = WIDTH'(tcnt_q);
                REG_TCMP: io_rdata_d = WIDTH'(tcmp_q);
                REG_STAT: io_rdata_d = WIDTH'({en_q, flag_q});
`endif
                default:  io_rdata_d = '0;
            endcase
        end
    end

    // Register the I/O selection and data to line up with the RAM's latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_sel_q   <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            io_sel_q   <= io_hit;
            io_rdata_q <= io_rdata_d;
        end
    end

    assign memdata = io_sel_q ? io_rdata_q : ram_q;

endmodule

// File: tb/tb_io_bus_responder.sv
// Self-checking bench for io_bus_responder. A behavioural model (register map
// values, a sample history for the switch synchronizer, and tick times derived
// from the cycle count since reset) predicts every output each cycle. Directed
// sequences cover the boundary cases. Random traffic follows them.
module tb_io_bus_responder;

    localparam int          WIDTH    = 16;
    localparam logic [15:0] IO_MEM   = 16'hCFFD;
    localparam int          PRESCALE = 4;
    localparam logic [15:0] IDLE_ADR = 16'h0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] adr;
    logic [15:0] memOut;
    logic        memwrite_a;
    logic [15:0] ram_q;
    logic        ram_we;
    logic [15:0] memdata;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic        irq;

    io_bus_responder #(
        .WIDTH   (WIDTH),
        .IO_MEM  (IO_MEM),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .adr       (adr),
        .memOut    (memOut),
        .memwrite_a(memwrite_a),
        .ram_q     (ram_q),
        .ram_we    (ram_we),
        .memdata   (memdata),
        .sw        (sw),
        .led       (led),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state.
    int          cyc;
    logic [7:0]  sw_drv;
    logic [7:0]  sw_hist[$];
    logic [7:0]  m_led;
    logic        m_flag;
    logic        m_en;
    logic        m_sel;
    logic [15:0] m_rdata;
    logic        last_ram_we;
`ifdef IO_TIMER_EN
    logic [15:0] m_tcnt;
    logic [15:0] m_tcmp;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] off);
        case (off)
            16'd0:   return {8'h00, m_led};
            16'd1:   return {8'h00, sw_hist[0]};
`ifdef IO_TIMER_EN
            16'd2:   return m_tcnt;
            16'd3:   return m_tcmp;
            16'd4:   return {14'd0, m_en, m_flag};
`endif
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        cyc     = 0;
        sw_hist = '{8'h00, 8'h00};
        m_led   = 8'h00;
        m_flag  = 1'b0;
        m_en    = 1'b0;
        m_sel   = 1'b0;
        m_rdata = 16'h0000;
`ifdef IO_TIMER_EN
        m_tcnt  = 16'h0000;
        m_tcmp  = 16'hFFFF;
`endif
    endtask

    // Called at posedge+1: pulses reset asynchronously mid-cycle, checks the
    // outputs immediately, then releases reset at the following posedge+1.
    task automatic apply_reset();
        ram_q      = 16'h1234;
        adr        = IDLE_ADR;
        memOut     = 16'h0000;
        memwrite_a = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_memdata", memdata, 16'h1234);
        check("rst_led", led, 8'h00);
        check("rst_irq", irq, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold_led", led, 8'h00);
        reset = 1'b1;
        model_reset();
    endtask

    // One bus cycle, entered at posedge+1 and left at the next posedge+1.
    task automatic cycle(input logic [15:0] a, input logic [15:0] d, input logic we);
        logic [15:0] off;
        logic        hit;
        logic [15:0] rd;
        logic [15:0] rq;
`ifdef IO_TIMER_EN
        logic        tick;
        logic        match;
`endif
        rq         = 16'($urandom);
        adr        = a;
        memOut     = d;
        memwrite_a = we;
        sw         = sw_drv;
        ram_q      = rq;
        @(negedge clk);
        hit = (a >= IO_MEM);
        off = a - IO_MEM;
        last_ram_we = ram_we;
        check("ram_we", ram_we, we && !hit);
        check("memdata", memdata, m_sel ? m_rdata : rq);
        check("led", led, m_led);
        check("irq", irq, m_flag && m_en);

        rd = hit ? model_read(off) : 16'h0000;
        if (we && hit && off == 16'd0) m_led = d[7:0];
`ifdef IO_TIMER_EN
        tick  = (cyc % PRESCALE) == (PRESCALE - 1);
        match = tick && (m_tcnt == m_tcmp);
        if (we && hit && off == 16'd2) m_tcnt = d;
        else if (tick) m_tcnt = m_tcnt + 16'd1;
        if (we && hit && off == 16'd3) m_tcmp = d;
        if (we && hit && off == 16'd4) begin
            m_en = d[1];
            if (d[0]) m_flag = 1'b0;
        end
        if (match) m_flag = 1'b1;
`endif
        void'(sw_hist.pop_front());
        sw_hist.push_back(sw_drv);
        m_sel   = hit;
        m_rdata = rd;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_until(input int n);
        while (cyc < n) cycle(IDLE_ADR, 16'h0000, 1'b0);
    endtask

    initial begin
        logic [15:0] exp_tcmp_rst;
        logic [15:0] a;
        logic [15:0] d;
        reset      = 1'b1;
        adr        = IDLE_ADR;
        memOut     = 16'h0000;
        memwrite_a = 1'b0;
        ram_q      = 16'h0000;
        sw_drv     = 8'h00;
        sw         = 8'h00;
        @(posedge clk);
        #1;
        apply_reset();

`ifdef IO_TIMER_EN
        exp_tcmp_rst = 16'hFFFF;
        // Compare/interrupt timing: ticks fall on cycles 3, 7, 11, 15.
        cycle(IO_MEM + 16'd3, 16'd3, 1'b1);
        cycle(IO_MEM + 16'd4, 16'h0002, 1'b1);
        idle_until(15);
        check("irq_before_4th_tick", irq, 1'b0);
        idle_until(16);
        check("irq_at_4th_tick", irq, 1'b1);
        cycle(IO_MEM + 16'd4, 16'h0003, 1'b1);
        check("irq_after_w1c", irq, 1'b0);
        cycle(IO_MEM + 16'd2, 16'd3, 1'b1);
        cycle(IDLE_ADR, 16'h0000, 1'b0);
        cycle(IO_MEM + 16'd4, 16'h0003, 1'b1);
        check("flag_set_beats_w1c", irq, 1'b1);
        // Wrap on the tick of cycle 23.
        cycle(IO_MEM + 16'd2, 16'hFFFF, 1'b1);
        cycle(IO_MEM + 16'd4, 16'h0003, 1'b1);
        idle_until(24);
        cycle(IO_MEM + 16'd2, 16'h0000, 1'b0);
        check("tcnt_wrap", memdata, 16'h0000);
        // Write on the tick of cycle 27 wins over the increment.
        idle_until(27);
        cycle(IO_MEM + 16'd2, 16'h1234, 1'b1);
        cycle(IO_MEM + 16'd2, 16'h0000, 1'b0);
        check("tcnt_write_beats_tick", memdata, 16'h1234);
`else
        exp_tcmp_rst = 16'h0000;
        for (int k = 2; k <= 4; k++) begin
            cycle(IO_MEM + 16'(k), 16'hFFFF, 1'b1);
            cycle(IO_MEM + 16'(k), 16'h0000, 1'b0);
            check("no_timer_reads_zero", memdata, 16'h0000);
        end
        cycle(IO_MEM + 16'd4, 16'h0002, 1'b1);
        repeat (100) cycle(IDLE_ADR, 16'h0000, 1'b0);
        check("no_timer_irq_low", irq, 1'b0);
`endif

        // Register map basics after a fresh reset.
        apply_reset();
        cycle(IO_MEM + 16'd3, 16'h0000, 1'b0);
        check("tcmp_reset_value", memdata, exp_tcmp_rst);
        cycle(IO_MEM, 16'h00A5, 1'b1);
        check("led_write_no_ram_we", last_ram_we, 1'b0);
        check("led_written", led, 8'hA5);
        cycle(IO_MEM - 16'd1, 16'h0077, 1'b1);
        check("ram_write_ram_we", last_ram_we, 1'b1);
        check("ram_write_led_kept", led, 8'hA5);
        cycle(IO_MEM, 16'h0000, 1'b0);
        check("led_readback", memdata, 16'h00A5);
        sw_drv = 8'h3C;
        cycle(IDLE_ADR, 16'h0000, 1'b0);
        cycle(IDLE_ADR, 16'h0000, 1'b0);
        cycle(IO_MEM + 16'd1, 16'h0000, 1'b0);
        check("sw_sync_read", memdata, 16'h003C);

        // Random traffic with a mid-run reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                cycle(IO_MEM, 16'h005A, 1'b1);
                apply_reset();
            end
            case ($urandom_range(0, 5))
                0, 1, 2: a = IO_MEM + 16'($urandom_range(0, 6));
                3:       a = IO_MEM - 16'd1;
                4:       a = 16'($urandom_range(0, int'(IO_MEM) - 2));
                default: a = 16'($urandom_range(int'(IO_MEM) + 7, 65535));
            endcase
            d = $urandom_range(0, 1) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            if ($urandom_range(0, 7) == 0) sw_drv = 8'($urandom);
            cycle(a, d, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
